// File: rtl/soc_dmem_arb_pkg.sv
// soc_dmem_arb_pkg: shared types for the DMEM port arbiter (response tracking, RAM ownership).
package soc_dmem_arb_pkg;
    typedef enum logic [1:0] {RSP_IDLE, RSP_CPU, RSP_DMA} rsp_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_WBUF, OWN_DMA} owner_t;
    localparam int STARVE_CNT_W = 8;
endpackage

// File: rtl/soc_dmem_wbuf.sv
// soc_dmem_wbuf: one-entry posted DMA write buffer (used by soc_dmem_arb under DMEM_ARB_WBUF_EN).
module soc_dmem_wbuf #(
    parameter int AW = 10
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_we,
    input  logic [15:0]   wr_data,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [1:0]    we,
    output logic [15:0]   data
);
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            valid <= 1'b0;
            addr  <= '0;
            we    <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= wr_addr;
            we    <= wr_we;
            data  <= wr_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/soc_dmem_arb.sv
// soc_dmem_arb: CPU-priority DMEM arbiter merging CPU and DMA masters onto one RAM port.
// Define DMEM_ARB_WBUF_EN to post DMA writes into a one-entry buffer while the CPU owns the RAM.
module soc_dmem_arb
    import soc_dmem_arb_pkg::*;
#(
    parameter int ADDR_MSB   = 9,
    parameter int STARVE_LIM = 64
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              cpu_cen,
    input  logic [1:0]        cpu_wen,
    input  logic [ADDR_MSB:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    input  logic              dma_req,
    input  logic [1:0]        dma_we,
    input  logic [ADDR_MSB:0] dma_addr,
    input  logic [15:0]       dma_din,
    output logic              dma_ready,
    output logic              dma_resp,
    output logic [15:0]       dma_dout,
    output logic              dma_starve,
    output logic              ram_ena,
    output logic [1:0]        ram_wea,
    output logic [ADDR_MSB:0] ram_addra,
    output logic [15:0]       ram_dina,
    input  logic [15:0]       ram_douta
);
    logic                    buf_valid;
    logic [ADDR_MSB:0]       buf_addr;
    logic [1:0]              buf_we;
    logic [15:0]             buf_data;
    logic                    post;
    owner_t                  owner;
    rsp_state_t              state;
    logic [STARVE_CNT_W-1:0] cnt;

`ifdef DMEM_ARB_WBUF_EN
    // Reads are never posted, so a read behind a buffered write naturally waits for the drain.
    assign post = !cpu_cen && !buf_valid && dma_req && (dma_we != 2'b00);
    soc_dmem_wbuf #(.AW(ADDR_MSB + 1)) u_wbuf (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .load    (post),
        .drain   (owner == OWN_WBUF),
        .wr_addr (dma_addr),
        .wr_we   (dma_we),
        .wr_data (dma_din),
        .valid   (buf_valid),
        .addr    (buf_addr),
        .we      (buf_we),
        .data    (buf_data)
    );
`else
    assign post      = 1'b0;
    assign buf_valid = 1'b0;
    assign buf_addr  = '0;
    assign buf_we    = '0;
    assign buf_data  = '0;
`endif

    always_comb begin
        owner     = !cpu_cen ? OWN_CPU : buf_valid ? OWN_WBUF : dma_req ? OWN_DMA : OWN_NONE;
        ram_ena   = owner != OWN_NONE;
        ram_wea   = owner == OWN_CPU ? ~cpu_wen : owner == OWN_WBUF ? buf_we : owner == OWN_DMA ? dma_we : 2'b00;
        ram_addra = owner == OWN_CPU ? cpu_addr : owner == OWN_WBUF ? buf_addr : dma_addr;
        ram_dina  = owner == OWN_CPU ? cpu_din : owner == OWN_WBUF ? buf_data : dma_din;
        dma_ready = (owner == OWN_DMA) || post;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= RSP_IDLE;
            cnt   <= '0;
        end else begin
            state <= (owner == OWN_CPU && cpu_wen == 2'b11) ? RSP_CPU :
                     (owner == OWN_DMA && dma_we == 2'b00)  ? RSP_DMA : RSP_IDLE;
            cnt   <= (!dma_req || dma_ready) ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
        end
    end

    assign dma_resp   = state == RSP_DMA;
    assign dma_starve = cnt >= STARVE_CNT_W'(STARVE_LIM);
    assign cpu_dout   = ram_douta;
    assign dma_dout   = ram_douta;
endmodule
